// File: rtl/prod_pkg.sv
// prod_pkg: shared types for the write-side producer scheduler.
//   state_e : scheduler FSM states (one-hot LED index matches encoding)
//   mode_e  : which producer(s) a run uses
//   src_e   : source tag, encoded to match the dm modulo input
package prod_pkg;

  localparam int unsigned DW_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_F    = 2'd1,
    MODE_T    = 2'd2,
    MODE_FT   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_F    = 2'd1,
    SRC_T    = 2'd2
  } src_e;

endpackage

// File: rtl/rr_burst_arb.sv
// rr_burst_arb: round-robin burst arbiter between the Fibonacci and Timer producers.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_load           start of a run: load i_load_grant, clear the burst count
//   i_load_grant     grant to begin the run with
//   i_acc            a word was accepted this cycle
//   i_mode           run mode; only MODE_FT ever switches the grant
//   i_hold           freeze grant and burst count (scheduler not in RUN)
//   o_grant          currently granted source (SRC_F or SRC_T)
module rr_burst_arb
  import prod_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_load,
  input  src_e  i_load_grant,
  input  logic  i_acc,
  input  mode_e i_mode,
  input  logic  i_hold,
  output src_e  o_grant
);

  localparam logic [7:0] BurstMax = 8'(BURST_LEN - 1);

  src_e       r_grant;
  logic [7:0] r_burst_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant     <= SRC_F;
      r_burst_cnt <= '0;
    end else if (i_load) begin
      r_grant     <= i_load_grant;
      r_burst_cnt <= '0;
    end else if (!i_hold && i_acc && (i_mode == MODE_FT)) begin
      // Last word of a burst: switch source on the same edge so the other
      // producer is enabled in the very next cycle.
      if (r_burst_cnt == BurstMax) begin
        r_burst_cnt <= '0;
        r_grant     <= (r_grant == SRC_F) ? SRC_T : SRC_F;
      end else begin
        r_burst_cnt <= r_burst_cnt + 8'd1;
      end
    end
  end

  assign o_grant = r_grant;

endmodule

// File: rtl/prod_sched.sv
// prod_sched: write-side scheduler for the shared producer buffer (clk_1 domain).
// Sequences the Fibonacci/Timer producers, muxes the granted word onto the
// buffer write port, stalls on full and drains on stop.
// Ports:
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   i_start_f/_t/_ft, i_stop            single-cycle command pulses
//   i_f_valid/i_f_out, i_t_valid/i_t_out producer words
//   i_buffer_full/_empty, i_data_valid_2 buffer and read-side status
//   o_f_en, o_t_en                      producer enables
//   o_data_1_en, o_data_1               buffer write strobe and data
//   o_modulo                            source tag (0 none, 1 Fib, 2 Timer)
//   o_led                               one-hot state {DRAIN, WAIT, RUN, IDLE}
//   o_word_cnt                          words written since last start
module prod_sched
  import prod_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned DW        = DW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start_f,
  input  logic          i_start_t,
  input  logic          i_start_ft,
  input  logic          i_stop,
  input  logic          i_f_valid,
  input  logic [DW-1:0] i_f_out,
  input  logic          i_t_valid,
  input  logic [DW-1:0] i_t_out,
  input  logic          i_buffer_full,
  input  logic          i_buffer_empty,
  input  logic          i_data_valid_2,
  output logic          o_f_en,
  output logic          o_t_en,
  output logic          o_data_1_en,
  output logic [DW-1:0] o_data_1,
  output logic [1:0]    o_modulo,
  output logic [3:0]    o_led,
  output logic [15:0]   o_word_cnt
);

  state_e      r_state;
  mode_e       r_mode;
  src_e        r_last_mod;
  logic [15:0] r_word_cnt;

  src_e        w_grant;
  src_e        w_load_grant;
  src_e        w_modulo;
  logic        w_run;
  logic        w_start_any;
  logic        w_acc;

  always_comb begin
    w_run        = (r_state == S_RUN);
    w_start_any  = (r_state == S_IDLE) && (i_start_f || i_start_t || i_start_ft);
    // Timer-first only for a lone start_t; any F or FT start begins on Fibonacci.
    w_load_grant = (i_start_t && !i_start_f && !i_start_ft) ? SRC_T : SRC_F;
    // Gating with full directly keeps enables low even in the cycle full rises.
    o_f_en       = w_run && (w_grant == SRC_F) && !i_buffer_full;
    o_t_en       = w_run && (w_grant == SRC_T) && !i_buffer_full;
    w_acc        = (o_f_en && i_f_valid) || (o_t_en && i_t_valid);
    o_data_1_en  = w_acc;
    o_data_1     = '0;
    if (w_acc) begin
      o_data_1 = (w_grant == SRC_F) ? i_f_out : i_t_out;
    end
    w_modulo = SRC_NONE;
    unique case (r_state)
      S_RUN, S_WAIT: w_modulo = w_grant;
      S_DRAIN:       w_modulo = r_last_mod;
      default:       w_modulo = SRC_NONE;
    endcase
    o_modulo   = w_modulo;
    o_led      = 4'b0001 << r_state;
    o_word_cnt = r_word_cnt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_NONE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start_ft || (i_start_f && i_start_t)) begin
            r_state <= S_RUN;
            r_mode  <= MODE_FT;
          end else if (i_start_f) begin
            r_state <= S_RUN;
            r_mode  <= MODE_F;
          end else if (i_start_t) begin
            r_state <= S_RUN;
            r_mode  <= MODE_T;
          end
        end
        S_RUN: begin
          if (i_stop) begin
            r_state <= S_DRAIN;
          end else if (i_buffer_full) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_stop) begin
            r_state <= S_DRAIN;
          end else if (!i_buffer_full) begin
            r_state <= S_RUN;
          end
        end
        S_DRAIN: begin
          if (i_buffer_empty && !i_data_valid_2) begin
            r_state <= S_IDLE;
            r_mode  <= MODE_NONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word_cnt <= '0;
      r_last_mod <= SRC_NONE;
    end else begin
      if (w_start_any) begin
        r_word_cnt <= '0;
      end else if (w_acc) begin
        r_word_cnt <= r_word_cnt + 16'd1;
      end
      // Remember the tag shown while active so DRAIN keeps displaying it.
      if ((r_state == S_RUN) || (r_state == S_WAIT)) begin
        r_last_mod <= w_modulo;
      end
    end
  end

  rr_burst_arb #(
    .BURST_LEN (BURST_LEN)
  ) u_arb (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load       (w_start_any),
    .i_load_grant (w_load_grant),
    .i_acc        (w_acc),
    .i_mode       (r_mode),
    .i_hold       (!w_run),
    .o_grant      (w_grant)
  );

endmodule

// File: doc/prod_sched.md
Name: prod_sched

Overview:
- Write-side scheduler for the shared producer buffer.
- Sequences the Fibonacci and Timer producers and arbitrates the buffer write port between them: single-source or round-robin interleaved bursts.
- Stalls the producers on buffer full and drains the buffer on stop.
- Runs in the producer/write clock domain (clk_1). Outputs the source tag consumed by dm (modulo) and one-hot state LEDs.

Parameters:
- BURST_LEN, 4, words accepted from one source before the grant switches in interleave mode (legal range 1..255).
- DW, 16, producer/buffer data width.

Ports:
- clk  in  1  write-side clock (clk_1).
- rst  in  1  asynchronous, active-low reset.
- start_f  in  1  single-cycle pulse (already edge-detected): run Fibonacci only.
- start_t  in  1  pulse: run Timer only.
- start_ft  in  1  pulse: run interleaved Fibonacci/Timer.
- stop  in  1  pulse: stop production and drain.
- f_valid  in  1  Fibonacci word valid.
- f_out  in  DW  Fibonacci word.
- t_valid  in  1  Timer word valid.
- t_out  in  DW  Timer word.
- buffer_full  in  1  buffer cannot accept a write.
- buffer_empty  in  1  buffer empty.
- data_valid_2  in  1  read side still presenting a word.
- f_en  out  1  Fibonacci produce enable.
- t_en  out  1  Timer produce enable.
- data_1_en  out  1  buffer write strobe.
- data_1  out  DW  buffer write data.
- modulo  out  2  current source tag: 0 = none, 1 = Fibonacci, 2 = Timer.
- led  out  4  one-hot state: [0] IDLE, [1] RUN, [2] WAIT, [3] DRAIN.
- word_cnt  out  16  words written since the last start.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, mode = NONE, grant = F, burst_cnt = 0, word_cnt = 0.
  - All enables and data_1_en = 0; data_1 = 0; modulo = 0; led = 4'b0001.
- Registered state: state, mode {NONE, F, T, FT}, grant {F, T}, burst_cnt (8 bit), word_cnt.
- IDLE:
  - start_ft, or start_f and start_t in the same cycle -> RUN, mode = FT, grant = F.
  - Otherwise start_f -> RUN, mode = F, grant = F.
  - Otherwise start_t -> RUN, mode = T, grant = T.
  - Any start clears burst_cnt and word_cnt.
  - stop in IDLE is ignored.
- RUN:
  - stop -> DRAIN. Stop has priority over full.
  - Otherwise buffer_full -> WAIT.
- WAIT:
  - stop -> DRAIN.
  - Otherwise !buffer_full -> RUN.
  - grant and burst_cnt are held.
- DRAIN:
  - Go to IDLE when buffer_empty = 1 and data_valid_2 = 0 in the same cycle.
  - mode resets to NONE on that transition.
  - Start pulses are ignored in DRAIN, WAIT and RUN.
- Enables (combinational):
  - f_en = (state == RUN) && grant == F && !buffer_full.
  - t_en is the same with grant == T.
  - This guarantees no enable in a full cycle, even in the cycle full first rises.
- Write path (combinational, zero latency):
  - acc = (f_en && f_valid) || (t_en && t_valid).
  - data_1_en = acc; data_1 = granted source data when acc, else 0.
  - The non-granted producer's valid is ignored, and its word is not lost: its en is low, so it does not advance.
- Counters:
  - On acc, word_cnt increments and wraps at 16'hFFFF -> 0.
  - In mode FT, on acc burst_cnt increments. When burst_cnt == BURST_LEN-1, burst_cnt clears and grant toggles in the same edge, so the other source is enabled on the next cycle.
  - Modes F and T never toggle grant.
- modulo:
  - 1 when state ∈ {RUN, WAIT} and grant = F.
  - 2 when state ∈ {RUN, WAIT} and grant = T.
  - In DRAIN it holds the last source value; in IDLE it is 0.
- Reset mid-operation: immediate return to the reset values above; the buffer contents are not this block's concern.

Decomposition:
- Shared package prod_pkg:
  - state encoding (S_IDLE, S_RUN, S_WAIT, S_DRAIN);
  - mode and source enums (SRC_NONE = 0, SRC_F = 1, SRC_T = 2, matching the dm modulo encoding);
  - DW default.
- One natural sub-module, rr_burst_arb: owns grant, burst_cnt and the toggle rule. Inputs are acc, mode and a hold signal; outputs are grant. The FSM, enables and write mux stay in prod_sched.

Test Plan:
1. Single-source Fibonacci:
   - Stimulus: reset, start_f, f_valid held high, producer words 1, 1, 2, 3, 5.
   - Required: data_1_en high for 5 cycles with data_1 = 1, 1, 2, 3, 5; modulo = 1; t_en = 0 throughout; word_cnt = 5.
2. Interleave, BURST_LEN = 4:
   - Stimulus: start_ft, both valids high.
   - Required: 4 Fibonacci writes, then 4 Timer writes, then 4 Fibonacci writes; modulo follows 1/2/1; word_cnt = 12.
3. Full backpressure:
   - Stimulus: buffer_full asserted after the 3rd write of burst 1 for 5 cycles.
   - Required: f_en = 0 and data_1_en = 0 in the first full cycle; led = 0100 (WAIT); on release, 1 more Fibonacci word is written, then grant switches (burst_cnt held at 3).
4. Stop during WAIT:
   - Stimulus: stop and buffer_full high in the same cycle.
   - Required: state = DRAIN. Then hold buffer_empty = 1 with data_valid_2 = 1 for 2 cycles, then drop data_valid_2 -> IDLE exactly 1 cycle after data_valid_2 falls; modulo = 0.
5. Simultaneous starts / ignored starts:
   - Stimulus: start_f and start_t in the same cycle.
   - Required: mode FT with grant F. A start_t pulse during RUN causes no change; stop in IDLE keeps led = 0001.
6. Async reset mid-burst:
   - Stimulus: drop rst between clock edges during interleave.
   - Required: data_1_en, f_en, t_en, modulo and word_cnt all 0 immediately (before the next edge); led = 0001.
